// File: rtl/snake_frame_reader.sv
// Snapshots the packed snake body on request and builds a double-buffered 16x16
// occupancy bitmap with a registered cell lookup. Optional macro: SNAKE_READER_PEND_EN.
module snake_frame_reader #(
    parameter  int unsigned GRID    = 16,
    parameter  int unsigned SEG_W   = 8,
    parameter  int unsigned MAX_SEG = 225,
    localparam int unsigned CW      = $clog2(GRID),
    localparam int unsigned AW      = 2 * CW,
    localparam int unsigned BODY_W  = MAX_SEG * SEG_W,
    localparam int unsigned IW      = $clog2(BODY_W),
    localparam int unsigned NW      = $clog2(MAX_SEG + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BODY_W-1:0] snake,
    input  logic [IW-1:0]     index,
    input  logic [CW-1:0]     xfood,
    input  logic [CW-1:0]     yfood,
    input  logic              frame_start,
    input  logic [CW-1:0]     rd_x,
    input  logic [CW-1:0]     rd_y,
    output logic [1:0]        rd_cell,
    output logic              busy,
    output logic              frame_ready,
    output logic [NW-1:0]     seg_count,
    output logic              self_hit,
    output logic              index_err
);

    localparam int unsigned CELLS = GRID * GRID;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        CLEAR = 3'd2,
        SCAN  = 3'd3,
        SWAP  = 3'd4
    } state_t;

    state_t            state;
    logic [BODY_W-1:0] snake_q;
    logic [AW-1:0]     food_q;
    logic [NW-1:0]     n_q;
    logic [NW-1:0]     k_q;
    logic              err_q;
    logic              hit_q;
    logic [AW-1:0]     head_q;
    logic [CELLS-1:0]  back;
    logic [CELLS-1:0]  front;
    logic [AW-1:0]     front_head;
    logic              front_head_valid;
    logic [AW-1:0]     front_food;
`ifdef SNAKE_READER_PEND_EN
    logic              pend_q;
`endif

    // A segment's packed {y,x} byte is already its cell address; the shadow shifts tail-first.
    logic [AW-1:0] seg_c;
    logic [AW-1:0] rd_addr_c;
    logic          idx_ok_c;
    logic [NW-1:0] n_c;
    logic [NW-1:0] last_c;

    assign seg_c     = snake_q[AW-1:0];
    assign rd_addr_c = {rd_y, rd_x};
    assign idx_ok_c  = (index[2:0] == 3'b111) && (index <= IW'(BODY_W - 1));
    assign n_c       = idx_ok_c ? (NW'(index[IW-1:3]) + NW'(1)) : '0;
    assign last_c    = n_q - NW'(1);

    // Frame build sequencer and front-buffer status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            snake_q          <= '0;
            food_q           <= '0;
            n_q              <= '0;
            k_q              <= '0;
            err_q            <= 1'b0;
            hit_q            <= 1'b0;
            head_q           <= '0;
            back             <= '0;
            front            <= '0;
            front_head       <= '0;
            front_head_valid <= 1'b0;
            front_food       <= '0;
            seg_count        <= '0;
            self_hit         <= 1'b0;
            index_err        <= 1'b0;
            busy             <= 1'b0;
            frame_ready      <= 1'b0;
`ifdef SNAKE_READER_PEND_EN
            pend_q           <= 1'b0;
`endif
        end else begin
            frame_ready <= 1'b0;
`ifdef SNAKE_READER_PEND_EN
            if (busy && frame_start) begin
                pend_q <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    snake_q <= snake;
                    food_q  <= {yfood, xfood};
                    n_q     <= n_c;
                    err_q   <= !idx_ok_c;
                    state   <= CLEAR;
                end
                CLEAR: begin
                    back   <= '0;
                    k_q    <= '0;
                    hit_q  <= 1'b0;
                    head_q <= '0;
                    state  <= (n_q == '0) ? SWAP : SCAN;
                end
                SCAN: begin
                    // The head is only recorded, so it can collide with body bits but never with itself
                    if (k_q == last_c) begin
                        hit_q  <= back[seg_c];
                        head_q <= seg_c;
                        state  <= SWAP;
                    end else begin
                        back[seg_c] <= 1'b1;
                    end
                    k_q     <= k_q + NW'(1);
                    snake_q <= snake_q >> SEG_W;
                end
                SWAP: begin
                    front            <= back;
                    front_head       <= head_q;
                    front_head_valid <= (n_q != '0);
                    front_food       <= food_q;
                    seg_count        <= n_q;
                    self_hit         <= hit_q;
                    index_err        <= err_q;
                    frame_ready      <= 1'b1;
`ifdef SNAKE_READER_PEND_EN
                    if (pend_q || frame_start) begin
                        state  <= LATCH;
                        pend_q <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered lookup from the front copy; food at (0,0) means no food
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cell <= 2'd0;
        end else if (front_head_valid && (front_head == rd_addr_c)) begin
            rd_cell <= 2'd3;
        end else if (front[rd_addr_c]) begin
            rd_cell <= 2'd2;
        end else if ((front_food != '0) && (front_food == rd_addr_c)) begin
            rd_cell <= 2'd1;
        end else begin
            rd_cell <= 2'd0;
        end
    end

endmodule

// File: tb/tb_snake_frame_reader.sv
// Randomized self-checking bench for snake_frame_reader against a cell-list reference model.
// Build with +define+SNAKE_READER_PEND_EN to check the pending-request variant.
module tb_snake_frame_reader;

    logic          clk;
    logic          reset_n;
    logic [1799:0] snake;
    logic [10:0]   index;
    logic [3:0]    xfood;
    logic [3:0]    yfood;
    logic          frame_start;
    logic [3:0]    rd_x;
    logic [3:0]    rd_y;
    logic [1:0]    rd_cell;
    logic          busy;
    logic          frame_ready;
    logic [7:0]    seg_count;
    logic          self_hit;
    logic          index_err;

    snake_frame_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .snake       (snake),
        .index       (index),
        .xfood       (xfood),
        .yfood       (yfood),
        .frame_start (frame_start),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_cell     (rd_cell),
        .busy        (busy),
        .frame_ready (frame_ready),
        .seg_count   (seg_count),
        .self_hit    (self_hit),
        .index_err   (index_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected front frame and the frame currently being built
    int exp_cell [256];
    int exp_count, exp_hit, exp_err;
    int nxt_cell [256];
    int nxt_count, nxt_hit, nxt_err;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1799:0] rand_snake(input logic [7:0] mask);
        logic [1799:0] s;
        for (int k = 0; k < 225; k++) s[8*k +: 8] = 8'($urandom) & mask;
        return s;
    endfunction

    // Reference: list of (x,y) segments, tail first; last listed one is the head
    task automatic model_frame(input logic [1799:0] sn, input int idx, input int fx, input int fy);
        bit body [256];
        int n;
        int head;
        bit valid;
        valid = (idx % 8 == 7) && (idx >= 7) && (idx <= 1799);
        n     = valid ? (idx + 1) / 8 : 0;
        foreach (body[i]) body[i] = 1'b0;
        head  = -1;
        for (int k = 0; k < n; k++) begin
            logic [7:0] s;
            int x, y;
            s = sn[8*k +: 8];
            x = int'(s[3:0]);
            y = int'(s[7:4]);
            if (k == n - 1) head = y * 16 + x;
            else body[y * 16 + x] = 1'b1;
        end
        nxt_count = n;
        nxt_err   = valid ? 0 : 1;
        nxt_hit   = (head >= 0 && body[head]) ? 1 : 0;
        for (int c = 0; c < 256; c++) begin
            if (c == head)                                 nxt_cell[c] = 3;
            else if (body[c])                              nxt_cell[c] = 2;
            else if ((fx != 0 || fy != 0) && c == fy * 16 + fx) nxt_cell[c] = 1;
            else                                           nxt_cell[c] = 0;
        end
    endtask

    task automatic commit_model();
        foreach (exp_cell[i]) exp_cell[i] = nxt_cell[i];
        exp_count = nxt_count;
        exp_hit   = nxt_hit;
        exp_err   = nxt_err;
    endtask

    task automatic clear_model();
        foreach (exp_cell[i]) exp_cell[i] = 0;
        exp_count = 0;
        exp_hit   = 0;
        exp_err   = 0;
    endtask

    // One cycle with a random lookup checked against the current front frame
    task automatic step_read();
        int a;
        a    = $urandom_range(0, 255);
        rd_x = 4'(a % 16);
        rd_y = 4'(a / 16);
        tick();
        check("rd_during", int'(rd_cell), exp_cell[a]);
    endtask

    task automatic read_cell(input int x, input int y, output int v);
        rd_x = 4'(x);
        rd_y = 4'(y);
        tick();
        v = int'(rd_cell);
    endtask

    task automatic read_all(input string tag);
        for (int c = 0; c < 256; c++) begin
            rd_x = 4'(c % 16);
            rd_y = 4'(c / 16);
            tick();
            check(tag, int'(rd_cell), exp_cell[c]);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, int'(seg_count), exp_count);
        check({tag, "_hit"},   int'(self_hit),  exp_hit);
        check({tag, "_err"},   int'(index_err), exp_err);
    endtask

    // Request a frame, scramble inputs after the snapshot, and check latency and results
    task automatic run_frame(input logic [1799:0] sn, input int idx, input int fx, input int fy,
                             input string tag);
        int lat, cyc;
        model_frame(sn, idx, fx, fy);
        lat         = nxt_count + 4;
        snake       = sn;
        index       = 11'(idx);
        xfood       = 4'(fx);
        yfood       = 4'(fy);
        frame_start = 1'b1;
        step_read();
        frame_start = 1'b0;
        cyc         = 1;
        check({tag, "_busy_rise"}, int'(busy), 1);
        while (!frame_ready && cyc < lat + 16) begin
            if (cyc == 2) begin
                snake = rand_snake(8'hFF);
                index = 11'($urandom_range(0, 2047));
                xfood = 4'($urandom);
                yfood = 4'($urandom);
            end
            step_read();
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy_fall"}, int'(busy), 0);
        commit_model();
        check_status(tag);
        step_read();
        check({tag, "_pulse"}, int'(frame_ready), 0);
    endtask

    initial begin
        logic [1799:0] s;
        logic [1799:0] sn2;
        int v, cyc, pulses, idx, n, fx, fy;
        logic [7:0] mask;

        reset_n     = 1'b0;
        snake       = '0;
        index       = '0;
        xfood       = '0;
        yfood       = '0;
        frame_start = 1'b0;
        rd_x        = '0;
        rd_y        = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(frame_ready), 0);
        check_status("rst");
        read_cell(7, 7, v);
        check("rst_cell", v, 0);

        // Initial snake: tail (1,1), (2,1), head (3,1), food (3,3)
        s = rand_snake(8'hFF);
        s[7:0]   = 8'h11;
        s[15:8]  = 8'h12;
        s[23:16] = 8'h13;
        run_frame(s, 23, 3, 3, "init");
        check("init_count_const", int'(seg_count), 3);
        read_cell(3, 1, v); check("init_x3y1", v, 3);
        read_cell(2, 1, v); check("init_x2y1", v, 2);
        read_cell(1, 1, v); check("init_x1y1", v, 2);
        read_cell(3, 3, v); check("init_x3y3", v, 1);
        read_cell(0, 0, v); check("init_x0y0", v, 0);

        // Self-hit: head returns to the tail cell (2,2)
        s = rand_snake(8'hFF);
        s[39:0] = {8'h22, 8'h32, 8'h33, 8'h23, 8'h22};
        run_frame(s, 39, 9, 9, "selfhit");
        check("selfhit_const", int'(self_hit), 1);
        read_cell(2, 2, v); check("selfhit_x2y2", v, 3);
        read_all("selfhit_map");

        // Malformed index: empty frame, food only
        run_frame(rand_snake(8'hFF), 20, 5, 7, "badidx");
        check("badidx_err_const", int'(index_err), 1);
        check("badidx_count_const", int'(seg_count), 0);
        read_all("badidx_map");

        // Food at (0,0) means no food
        s = rand_snake(8'hFF);
        s[15:0] = {8'h44, 8'h54};
        run_frame(s, 15, 0, 0, "nofood");
        read_cell(0, 0, v); check("nofood_x0y0", v, 0);
        read_cell(4, 4, v); check("nofood_head", v, 3);

        // Randomized frames, narrow masks force duplicates and collisions
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0:       mask = 8'hFF;
                1:       mask = 8'h33;
                default: mask = 8'h11;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                idx = $urandom_range(0, 2047);
                if (idx % 8 == 7 && idx <= 1799) idx = idx - 1;
            end else begin
                n   = $urandom_range(1, 60);
                idx = 8 * n - 1;
            end
            fx = $urandom_range(0, 15);
            fy = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            if (fy == 0 && $urandom_range(0, 1) == 0) fx = 0;
            run_frame(rand_snake(mask), idx, fx, fy, "rand");
            read_all("rand_map");
        end

        // Max-length frame with a second request while busy and inputs changed after the snapshot
        s   = rand_snake(8'hFF);
        sn2 = rand_snake(8'h77);
        model_frame(s, 1799, 5, 9);
        snake       = s;
        index       = 11'd1799;
        xfood       = 4'd5;
        yfood       = 4'd9;
        frame_start = 1'b1;
        step_read();
        frame_start = 1'b0;
        cyc         = 1;
        while (!frame_ready && cyc < 260) begin
            if (cyc == 2) begin
                snake = sn2;
                xfood = 4'd2;
                yfood = 4'd14;
            end
            if (cyc == 10) frame_start = 1'b1;
            step_read();
            frame_start = 1'b0;
            cyc++;
        end
        check("ovr_latency", cyc, 229);
        commit_model();
        check_status("ovr");
`ifdef SNAKE_READER_PEND_EN
        check("ovr_busy_held", int'(busy), 1);
        model_frame(sn2, 1799, 2, 14);
        step_read();
        cyc++;
        while (!frame_ready && cyc < 520) begin
            step_read();
            cyc++;
        end
        check("ovr_second_latency", cyc, 457);
        commit_model();
        check_status("ovr2");
        check("ovr2_busy_fall", int'(busy), 0);
`else
        check("ovr_busy_fall", int'(busy), 0);
        pulses = 0;
        repeat (240) begin
            step_read();
            if (frame_ready) pulses++;
        end
        check("ovr_no_second", pulses, 0);
`endif
        read_all("ovr_map");

        // Reset in the middle of a scan abandons the frame
        snake       = rand_snake(8'hFF);
        index       = 11'(8 * 50 - 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (20) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(frame_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        clear_model();
        pulses = 0;
        repeat (70) begin
            step_read();
            if (frame_ready) pulses++;
        end
        check("midrst_no_ready", pulses, 0);
        check("midrst_busy_after", int'(busy), 0);
        check_status("midrst");
        read_all("midrst_map");

        // Recovery after reset
        run_frame(rand_snake(8'h33), 8 * 12 - 1, 6, 1, "recover");
        read_all("recover_map");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
